// File: rtl/audio_out_fifo.sv
// Output frame FIFO between the sequencer results port and i2s_tx: stages L/R, commits on done rise,
// releases one frame per I2S frame strobe. Define AUDIO_OUT_HOLD_EN to hold the last samples on underrun.
module audio_out_fifo #(
  parameter int DEPTH = 8,
  parameter int PRIME = 2
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic [3:0]               out_addr,
  input  logic [15:0]              out_audio,
  input  logic                     out_we,
  input  logic                     done,
  input  logic                     frame_start,
  input  logic                     clr_counts,
  output logic [15:0]              left,
  output logic [15:0]              right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     running,
  output logic [7:0]               overflow_count,
  output logic [7:0]               underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {ST_PRIME, ST_RUN} state_t;

  state_t        state, next_state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   stage_l, stage_r;
  logic          done_d, done_armed;
  logic          commit, push, pop, underrun, overflow;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign running = (state == ST_RUN);
  assign head    = mem[rd_ptr[AW-1:0]];

  // done_armed blocks a commit from a done level that was already high when reset released
  assign commit   = done && !done_d && done_armed;
  assign push     = commit && (!full || pop);
  assign overflow = commit && full && !pop;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= ST_PRIME;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    underrun   = 1'b0;
    case (state)
      ST_PRIME: if (level >= PW'(PRIME)) next_state = ST_RUN;
      ST_RUN: begin
        if (frame_start) begin
          if (empty) begin
            underrun   = 1'b1;
            next_state = ST_PRIME;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: next_state = ST_PRIME;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      stage_l    <= '0;
      stage_r    <= '0;
      done_d     <= 1'b0;
      done_armed <= 1'b0;
    end else begin
      done_d     <= done;
      done_armed <= done_armed | !done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (out_we && out_addr == 4'd0) stage_l <= out_audio;
      if (out_we && out_addr == 4'd1) stage_r <= out_audio;
    end
  end

  // Push stores the pre-edge staging pair, so a coincident out_we lands in the next frame
  always_ff @(posedge ck) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {stage_r, stage_l};
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      left  <= '0;
      right <= '0;
    end else if (pop) begin
      left  <= head[15:0];
      right <= head[31:16];
    end else if (underrun) begin
`ifdef AUDIO_OUT_HOLD_EN
      left  <= left;
      right <= right;
`else
      left  <= '0;
      right <= '0;
`endif
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      overflow_count <= '0;
      underrun_count <= '0;
    end else if (clr_counts) begin
      overflow_count <= '0;
      underrun_count <= '0;
    end else begin
      if (overflow && overflow_count != 8'hFF) overflow_count <= overflow_count + 8'd1;
      if (underrun && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_out_fifo.sv
// Randomized bench for audio_out_fifo against a queue-based frame model; honours AUDIO_OUT_HOLD_EN.
module tb_audio_out_fifo;

  localparam int DEPTH = 8;
  localparam int PRIME = 2;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  out_addr = '0;
  logic [15:0] out_audio = '0;
  logic        out_we = 1'b0;
  logic        done = 1'b0;
  logic        frame_start = 1'b0;
  logic        clr_counts = 1'b0;
  logic [15:0] left, right;
  logic [3:0]  level;
  logic        empty, full, running;
  logic [7:0]  overflow_count, underrun_count;

  int total = 0;
  int bad = 0;

  logic [31:0] q[$];
  logic [15:0] m_l, m_r, m_left, m_right;
  bit          m_run, m_done_prev, m_seen_low;
  int          m_ovf, m_und;

  audio_out_fifo #(.DEPTH(DEPTH), .PRIME(PRIME)) dut (
    .ck(ck), .rst(rst), .out_addr(out_addr), .out_audio(out_audio), .out_we(out_we),
    .done(done), .frame_start(frame_start), .clr_counts(clr_counts),
    .left(left), .right(right), .level(level), .empty(empty), .full(full),
    .running(running), .overflow_count(overflow_count), .underrun_count(underrun_count)
  );

  always #5 ck = ~ck;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_l = '0; m_r = '0; m_left = '0; m_right = '0;
    m_run = 0; m_done_prev = 0; m_seen_low = 0;
    m_ovf = 0; m_und = 0;
  endtask

  // One clock of the frame model, evaluated on the inputs present before the edge
  task automatic modelStep();
    int pre;
    bit commit, pop_ok, under;
    logic [31:0] f;
    pre    = q.size();
    commit = done && !m_done_prev && m_seen_low;
    pop_ok = m_run && frame_start && pre > 0;
    under  = m_run && frame_start && pre == 0;
    if (pop_ok) begin
      f = q.pop_front();
      m_left  = f[15:0];
      m_right = f[31:16];
    end
    if (under) begin
      if (m_und < 255) m_und++;
`ifndef AUDIO_OUT_HOLD_EN
      m_left  = '0;
      m_right = '0;
`endif
    end
    if (commit) begin
      if (pre < DEPTH || pop_ok) q.push_back({m_r, m_l});
      else if (m_ovf < 255) m_ovf++;
    end
    if (m_run) m_run = !under;
    else       m_run = (pre >= PRIME);
    if (clr_counts) begin
      m_ovf = 0;
      m_und = 0;
    end
    if (out_we && out_addr == 4'd0) m_l = out_audio;
    if (out_we && out_addr == 4'd1) m_r = out_audio;
    m_done_prev = done;
    if (!done) m_seen_low = 1;
  endtask

  task automatic compareAll();
    checkOutput("left", left, m_left);
    checkOutput("right", right, m_right);
    checkOutput("level", level, q.size());
    checkOutput("empty", empty, q.size() == 0);
    checkOutput("full", full, q.size() == DEPTH);
    checkOutput("running", running, m_run);
    checkOutput("overflow_count", overflow_count, m_ovf);
    checkOutput("underrun_count", underrun_count, m_und);
  endtask

  task automatic driveCycle(input bit r, input bit d, input bit fs, input bit we,
                            input logic [3:0] a, input logic [15:0] s, input bit clr);
    @(negedge ck);
    rst = r; done = d; frame_start = fs; out_we = we; out_addr = a; out_audio = s; clr_counts = clr;
    if (r) modelReset();
    else   modelStep();
    @(posedge ck);
    #1;
    compareAll();
  endtask

  // Probabilities are 1-in-N; N=0 disables that input (done is then held low)
  task automatic applyStimulus(input int cycles, input int done_p, input int fs_p,
                               input int clr_p, input int rst_p);
    bit d;
    for (int i = 0; i < cycles; i++) begin
      d = done;
      if (done_p == 0) d = 0;
      else if ($urandom % done_p == 0) d = !d;
      driveCycle(rst_p != 0 && ($urandom % rst_p) == 0, d,
                 fs_p != 0 && ($urandom % fs_p) == 0,
                 $urandom % 2 == 0, 4'($urandom % 4), 16'($urandom),
                 clr_p != 0 && ($urandom % clr_p) == 0);
    end
  endtask

  initial begin
    modelReset();
    driveCycle(1, 0, 0, 0, 4'd0, 16'h0, 0);
    driveCycle(1, 0, 1, 0, 4'd0, 16'h0, 0);
    applyStimulus(20, 0, 3, 0, 0);

    driveCycle(0, 0, 0, 1, 4'd0, 16'h1234, 0);
    driveCycle(0, 0, 0, 1, 4'd1, 16'hABCD, 0);
    driveCycle(0, 1, 0, 0, 4'd0, 16'h0, 0);
    driveCycle(0, 0, 0, 0, 4'd0, 16'h0, 0);
    driveCycle(0, 1, 0, 0, 4'd0, 16'h0, 0);
    driveCycle(0, 0, 0, 0, 4'd0, 16'h0, 0);
    checkOutput("plan_running", running, 1);
    driveCycle(0, 0, 1, 0, 4'd0, 16'h0, 0);
    checkOutput("plan_left", left, 16'h1234);
    checkOutput("plan_right", right, 16'hABCD);
    checkOutput("plan_level", level, 1);

    driveCycle(0, 1, 0, 1, 4'd0, 16'h5555, 0);
    driveCycle(0, 0, 0, 0, 4'd0, 16'h0, 0);
    driveCycle(0, 1, 0, 0, 4'd0, 16'h0, 0);

    applyStimulus(400, 3, 8, 0, 0);
    applyStimulus(700, 1, 0, 0, 0);
    applyStimulus(400, 10, 2, 0, 0);
    applyStimulus(600, 3, 6, 50, 150);
    applyStimulus(400, 2, 3, 40, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
